// File: rtl/nrisc_stack_if.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_stack_if
// Brief    : STACK control bus between the NRISC CPU (master) and the
//            return-address stack controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface nrisc_stack_if #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 16,
    parameter int FLAG_W = 3
);
    localparam int c_SPW = $clog2(DEPTH) + 1;

    logic [1:0]        STACK_ctrl;
    logic [PC_W-1:0]   STACK_pc_in;
    logic [FLAG_W-1:0] STACK_flags_in;
    logic              STACK_irq_req;
    logic              STACK_clr_err;
    logic              STACK_busy;
    logic [PC_W-1:0]   STACK_pc_out;
    logic              STACK_pc_valid;
    logic [FLAG_W-1:0] STACK_flags_out;
    logic              STACK_flags_restore;
    logic              STACK_irq_ack;
    logic              STACK_int_en;
    logic [c_SPW-1:0]  STACK_depth;
    logic              STACK_overflow;
    logic              STACK_underflow;
    logic              STACK_frame_err;

    modport master (
        output STACK_ctrl, STACK_pc_in, STACK_flags_in, STACK_irq_req, STACK_clr_err,
        input  STACK_busy, STACK_pc_out, STACK_pc_valid, STACK_flags_out,
               STACK_flags_restore, STACK_irq_ack, STACK_int_en, STACK_depth,
               STACK_overflow, STACK_underflow, STACK_frame_err
    );

    modport slave (
        input  STACK_ctrl, STACK_pc_in, STACK_flags_in, STACK_irq_req, STACK_clr_err,
        output STACK_busy, STACK_pc_out, STACK_pc_valid, STACK_flags_out,
               STACK_flags_restore, STACK_irq_ack, STACK_int_en, STACK_depth,
               STACK_overflow, STACK_underflow, STACK_frame_err
    );
endinterface
`default_nettype wire

// File: rtl/nrisc_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_stack_ctrl
// Brief    : Hardware return-address stack for CALL/RET/RETI and interrupt
//            entry. Entries hold {irq_mark, flags, pc}; sp is the next free
//            slot and saturates at 0 and DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module nrisc_stack_ctrl #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 16,
    parameter int FLAG_W = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    nrisc_stack_if.slave       io_stack
);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_SPW   = c_AW + 1;
    localparam int c_ENT_W = 1 + FLAG_W + PC_W;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_POP  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_SPW-1:0]    r_sp;
    logic [c_ENT_W-1:0]  r_mem [DEPTH];
    logic                r_pop_reti;
    logic                r_irq_pending;
    logic                r_int_en;
    logic [PC_W-1:0]     r_pc_out;
    logic [FLAG_W-1:0]   r_flags_out;
    logic                r_pc_valid;
    logic                r_flags_restore;
    logic                r_irq_ack;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_frame_err;

    logic                w_call;
    logic                w_pop_go;
    logic                w_pop_unf;
    logic                w_irq_srv;
    logic                w_irq_take;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic [c_ENT_W-1:0]  w_push_ent;
    logic [c_ENT_W-1:0]  w_rd_ent;
    logic                w_rd_mark;
    logic [FLAG_W-1:0]   w_rd_flags;
    logic [PC_W-1:0]     w_rd_pc;
    logic                w_in_pop;
    logic                w_ovf_set;
    logic                w_ferr_set;

    assign w_full     = (r_sp == c_SPW'(DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_in_pop   = (r_state == S_POP);
    // A request arriving on an idle cycle is serviced at once rather than
    // waiting a cycle in the pending latch.
    assign w_irq_take = r_irq_pending | (io_stack.STACK_irq_req & r_int_en);
    assign w_push     = (w_call | w_irq_srv) & ~w_full;
    assign w_ovf_set  = (w_call | w_irq_srv) & w_full;
    assign w_push_ent = w_irq_srv ? {1'b1, io_stack.STACK_flags_in, io_stack.STACK_pc_in}
                                  : {1'b0, {FLAG_W{1'b0}}, io_stack.STACK_pc_in};
    // sp was already decremented on pop entry, so it addresses the top entry.
    assign w_rd_ent   = r_mem[r_sp[c_AW-1:0]];
    assign {w_rd_mark, w_rd_flags, w_rd_pc} = w_rd_ent;
    assign w_ferr_set = w_in_pop & (r_pop_reti ? ~w_rd_mark : w_rd_mark);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and command decode; CPU ctrl outranks a waiting interrupt.
    always_comb begin
        w_state_nxt = r_state;
        w_call      = 1'b0;
        w_pop_go    = 1'b0;
        w_pop_unf   = 1'b0;
        w_irq_srv   = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (io_stack.STACK_ctrl)
                    2'b01: w_call = 1'b1;
                    2'b10, 2'b11: begin
                        if (!w_empty) begin
                            w_pop_go    = 1'b1;
                            w_state_nxt = S_POP;
                        end else begin
                            w_pop_unf = 1'b1;
                        end
                    end
                    default: w_irq_srv = w_irq_take;
                endcase
            end
            S_POP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_sp[c_AW-1:0]] <= w_push_ent;
    end

    // Stack pointer, interrupt bookkeeping, pop delivery and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp            <= '0;
            r_pop_reti      <= 1'b0;
            r_irq_pending   <= 1'b0;
            r_int_en        <= 1'b1;
            r_pc_out        <= '0;
            r_flags_out     <= '0;
            r_pc_valid      <= 1'b0;
            r_flags_restore <= 1'b0;
            r_irq_ack       <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            r_pc_valid      <= 1'b0;
            r_flags_restore <= 1'b0;
            r_irq_ack       <= w_irq_srv;

            if (w_push)        r_sp <= r_sp + c_SPW'(1);
            else if (w_pop_go) r_sp <= r_sp - c_SPW'(1);

            if (w_pop_go) r_pop_reti <= io_stack.STACK_ctrl[0];

            if (w_irq_srv)
                r_irq_pending <= 1'b0;
            else if (io_stack.STACK_irq_req && r_int_en)
                r_irq_pending <= 1'b1;

            if (w_irq_srv)
                r_int_en <= 1'b0;
            else if (w_in_pop && r_pop_reti)
                r_int_en <= 1'b1;

            if (w_in_pop) begin
                r_pc_out   <= w_rd_pc;
                r_pc_valid <= 1'b1;
                if (r_pop_reti) begin
                    r_flags_out     <= w_rd_flags;
                    r_flags_restore <= 1'b1;
                end
            end else if (w_pop_unf) begin
                // Empty pop still answers so the CPU never stalls forever.
                r_pc_out   <= '0;
                r_pc_valid <= 1'b1;
            end

            r_overflow  <= w_ovf_set  | (r_overflow  & ~io_stack.STACK_clr_err);
            r_underflow <= w_pop_unf  | (r_underflow & ~io_stack.STACK_clr_err);
            r_frame_err <= w_ferr_set | (r_frame_err & ~io_stack.STACK_clr_err);
        end
    end

    assign io_stack.STACK_busy          = w_in_pop;
    assign io_stack.STACK_pc_out        = r_pc_out;
    assign io_stack.STACK_pc_valid      = r_pc_valid;
    assign io_stack.STACK_flags_out     = r_flags_out;
    assign io_stack.STACK_flags_restore = r_flags_restore;
    assign io_stack.STACK_irq_ack       = r_irq_ack;
    assign io_stack.STACK_int_en        = r_int_en;
    assign io_stack.STACK_depth         = r_sp;
    assign io_stack.STACK_overflow      = r_overflow;
    assign io_stack.STACK_underflow     = r_underflow;
    assign io_stack.STACK_frame_err     = r_frame_err;
endmodule
`default_nettype wire
